// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys fetched by rk_idx.
// Define AES_INV_CIPHER_EARLY_READY_EN to accept the next block in DONE as the result leaves.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_cipher_iter: only NR=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine map, then GF(2^8) inverse as x^254; a pure 8-bit function, so it folds to a table.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a;
    logic [7:0] sq;
    logic [7:0] r;
    a  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = gf_mul(a[i], 8'h0e) ^ gf_mul(a[(i+1)%4], 8'h0b) ^
                         gf_mul(a[(i+2)%4], 8'h0d) ^ gf_mul(a[(i+3)%4], 8'h09);
    end
    return res;
  endfunction

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [3:0]   cnt_q;
  logic         out_valid_q;
  logic         in_ready_q;
  logic         busy_q;

  logic [127:0] sub_bytes;
  logic [127:0] ark_bytes;
  logic [127:0] mix_bytes;
  logic [127:0] load_d;
  logic         take_next;

  genvar gi;

  // Byte k sits at column k/4, row k%4; row r rotates right by r, so it reads column c-r.
  for (gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
    assign sub_bytes[127-8*gi -: 8] = inv_sbox(state_q[127-8*SRC -: 8]);
  end

  assign ark_bytes = sub_bytes ^ rk;

  for (gi = 0; gi < 4; gi++) begin : g_col
    assign mix_bytes[127-32*gi -: 32] = inv_mix_col(ark_bytes[127-32*gi -: 32]);
  end

  assign load_d = in_block ^ rk;

`ifdef AES_INV_CIPHER_EARLY_READY_EN
  localparam logic [3:0] DONE_RK_IDX = 4'd10;
  assign take_next = in_valid;
  assign in_ready  = in_ready_q || (out_valid_q && out_ready);
`else
  localparam logic [3:0] DONE_RK_IDX = 4'd0;
  assign take_next = 1'b0;
  assign in_ready  = in_ready_q;
`endif

  always_comb begin
    rk_idx = 4'd0;
    case (fsm_q)
      IDLE:    rk_idx = 4'd10;
      ROUND:   rk_idx = cnt_q;
      FINAL:   rk_idx = 4'd0;
      DONE:    rk_idx = DONE_RK_IDX;
      default: rk_idx = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= load_d;
            cnt_q      <= 4'd9;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= ROUND;
          end
        end
        ROUND: begin
          state_q <= mix_bytes;
          if (cnt_q == 4'd1) fsm_q <= FINAL;
          else               cnt_q <= cnt_q - 4'd1;
        end
        FINAL: begin
          state_q     <= ark_bytes;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          fsm_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (take_next) begin
              state_q <= load_d;
              cnt_q   <= 4'd9;
              busy_q  <= 1'b1;
              fsm_q   <= ROUND;
            end else begin
              in_ready_q <= 1'b1;
              fsm_q      <= IDLE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_block = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: plaintexts are pushed on acceptance, a monitor pops on output.
// Random traffic is produced by a forward AES-128 reference cipher with its own key schedule.
module tb_aes_inv_cipher_iter;

`ifdef AES_INV_CIPHER_EARLY_READY_EN
  localparam int EXP_PERIOD = 11;
`else
  localparam int EXP_PERIOD = 12;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [3:0]   rk_idx;
  logic [127:0] out_block;
  logic [127:0] rk;

  logic [127:0] rk_tab [11];
  logic [7:0]   sbox_t [256];
  logic [127:0] sb_q [$];
  int           tests = 0;
  int           fails = 0;
  int           cycle = 0;
  bit           rand_ready_en = 1'b0;

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  assign rk = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box: brute-force multiplicative inverse followed by the FIPS-197 affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[8'(x)] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rk_tab[0];
    for (int k = 0; k < 16; k++) s[k] = v[127-8*k -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_t[s[((k/4 + k%4) % 4)*4 + k%4]];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++)
          s[4*c+i] = (r == 10) ? t[4*c+i] :
                     gm(t[4*c+i], 8'h02) ^ gm(t[4*c+(i+1)%4], 8'h03) ^
                     t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4];
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_tab[r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) v[127-8*k -: 8] = s[k];
    return v;
  endfunction

  task automatic check_blk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    in_block = ct;
    in_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(pt);
        acc = cycle;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 for block %h", ct);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int t = 0; t < limit && sb_q.size() != 0; t++) @(negedge clk);
    check_int("drain", sb_q.size(), 0);
  endtask

  task automatic wait_valid(input int limit);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < limit && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check_int("out_valid_timeout", int'(seen), 1);
  endtask

  // Monitor: any output handshake consumes the oldest expected plaintext.
  initial begin
    int           n_out;
    logic [127:0] exp_pt;
    n_out = 0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h, required no output", out_block);
        end else begin
          exp_pt = sb_q.pop_front();
          $display("[TB] out %0d pt=%h", n_out, out_block);
          check_blk("plaintext", out_block, exp_pt);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    forever begin
      if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  end

  initial begin
    int           acc;
    int           prev;
    logic [127:0] held;
    logic [127:0] pt;
    build_sbox();
    load_key(C1_KEY);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_in_ready", int'(in_ready), 1);
    check_int("rst_busy", int'(busy), 0);
    check_blk("rst_out_block", out_block, '0);
    check_int("idle_rk_idx", int'(rk_idx), 10);

    // FIPS-197 C.1: rk_idx walks 9..1 then 0 after acceptance, result appears after 10 edges.
    @(posedge clk);
    #1 send(C1_CT, C1_PT, acc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_int("c1_rk_idx", int'(rk_idx), (k < 9) ? 9 - k : 0);
      check_int("c1_early_valid", int'(out_valid), 0);
      check_int("c1_busy", int'(busy), 1);
    end
    @(negedge clk);
    check_int("c1_latency_valid", int'(out_valid), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(20);

    // FIPS-197 B with 20 cycles of backpressure and an ignored in_valid.
    @(posedge clk);
    #1 out_ready = 1'b0;
    load_key(B_KEY);
    send(B_CT, B_PT, acc);
    wait_valid(40);
    held = out_block;
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_block = C1_CT;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_int("bp_out_valid", int'(out_valid), 1);
      check_blk("bp_out_block_stable", out_block, held);
      check_int("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(10);
    repeat (2) @(negedge clk);
    check_int("bp_not_accepted_busy", int'(busy), 0);
    check_int("bp_not_accepted_valid", int'(out_valid), 0);

    // Reset in the fifth ROUND cycle discards the block.
    @(posedge clk);
    #1 load_key(C1_KEY);
    send(C1_CT, C1_PT, acc);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("midrst_out_valid", int'(out_valid), 0);
    check_int("midrst_in_ready", int'(in_ready), 1);
    check_int("midrst_busy", int'(busy), 0);
    check_blk("midrst_out_block", out_block, '0);
    @(posedge clk);
    #1 send(C1_CT, C1_PT, acc);
    wait_drain(40);

    // Streaming: 96 random blocks under a random key with random gaps and backpressure.
    @(posedge clk);
    #1 load_key({$urandom(), $urandom(), $urandom(), $urandom()});
    rand_ready_en = 1'b1;
    for (int i = 0; i < 96; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(aes_enc(pt), pt, acc);
    end
    wait_drain(600);

    // Throughput with in_valid and out_ready held high.
    @(posedge clk);
    #1 rand_ready_en = 1'b0;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(aes_enc(pt), pt, acc);
      if (i > 0) check_int("throughput_period", acc - prev, EXP_PERIOD);
      prev = acc;
    end
    wait_drain(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
